// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE sequencer: FSM states, error codes and the PE micro-op bundle.
package pe_ctrl_pkg;

    localparam int unsigned XLEN = 16;

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StRelu,
        StWaitOut,
        StResp,
        StAbort,
        StFlush
    } state_e;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrNumMac  = 2'd1;
    localparam logic [1:0] ErrIllegal = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    typedef struct packed {
        logic in_valid;
        logic flush;
        logic out_en;
        logic calc_bias;
        logic calc_relu;
    } uop_t;

    localparam uop_t UopNop = '0;

endpackage

// File: rtl/pe_seq_ctrl.sv
// Per-pixel command sequencer for one PE: streams operand pairs, issues bias/relu/out_en/flush
// micro-ops, returns the PE result over valid/ready, and aborts on PE errors or output timeout.
module pe_seq_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned OUT_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [CNT_W-1:0]       cmd_num_mac,
    input  logic                   cmd_bias,
    input  logic                   cmd_relu,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic signed [XLEN-1:0] op_x,
    input  logic signed [XLEN-1:0] op_w,
    output logic                   pe_in_valid,
    output logic                   pe_flush,
    output logic                   pe_out_en,
    output logic                   pe_calc_bias,
    output logic                   pe_calc_relu,
    output logic signed [XLEN-1:0] pe_x,
    output logic signed [XLEN-1:0] pe_weight,
    input  logic signed [XLEN-1:0] pe_result,
    input  logic                   pe_out_valid,
    input  logic                   pe_illegal,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [XLEN-1:0] res_data,
    output logic                   busy,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam int unsigned TO_W = $clog2(OUT_TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       remaining_q, remaining_d;
    logic                   bias_q, bias_d;
    logic                   relu_q, relu_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    uop_t                   uop_q, uop_d;
    logic signed [XLEN-1:0] x_q, x_d;
    logic signed [XLEN-1:0] w_q, w_d;
    logic signed [XLEN-1:0] res_data_q, res_data_d;
    logic                   err_q, err_d;
    logic [1:0]             err_code_q, err_code_d;
    logic                   cmd_ready_q, op_ready_q, busy_q, res_valid_q;
    logic                   op_fire;

    assign op_fire = (state_q == StMac) && op_valid && op_ready_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bias_d      = bias_q;
        relu_d      = relu_q;
        to_cnt_d    = to_cnt_q;
        uop_d       = UopNop;
        x_d         = x_q;
        w_d         = w_q;
        res_data_d  = res_data_q;
        err_d       = err_q;
        err_code_d  = err_code_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    err_d       = 1'b0;
                    err_code_d  = ErrNone;
                    bias_d      = cmd_bias;
                    relu_d      = cmd_relu;
                    remaining_d = cmd_num_mac;
                    if (cmd_num_mac == '0) begin
                        err_d      = 1'b1;
                        err_code_d = ErrNumMac;
                        state_d    = StFlush;
                    end else begin
                        state_d = StMac;
                    end
                end
            end
            StMac: begin
                if (op_fire) begin
                    uop_d.in_valid = 1'b1;
                    x_d            = op_x;
                    w_d            = op_w;
                    remaining_d    = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        // Bias rides on the last MAC; out_en moves to the relu cycle if present.
                        uop_d.calc_bias = bias_q;
                        uop_d.out_en    = !relu_q;
                        to_cnt_d        = '0;
                        state_d         = relu_q ? StRelu : StWaitOut;
                    end
                end
            end
            StRelu: begin
                uop_d.calc_relu = 1'b1;
                uop_d.out_en    = 1'b1;
                to_cnt_d        = '0;
                state_d         = StWaitOut;
            end
            StWaitOut: begin
                if (pe_out_valid) begin
                    res_data_d = pe_result;
                    state_d    = StResp;
                end else if (to_cnt_q == TO_W'(OUT_TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = ErrTimeout;
                    state_d    = StAbort;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            StResp: begin
                if (res_ready) begin
                    state_d = StFlush;
                end
            end
            StAbort: state_d = StFlush;
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A PE fault overrides any progress this cycle; the consumed operand is dropped.
        if (pe_illegal && (state_q inside {StMac, StRelu, StWaitOut, StResp}) && !err_q) begin
            err_d      = 1'b1;
            err_code_d = ErrIllegal;
            uop_d      = UopNop;
            state_d    = StAbort;
        end

        if (state_d == StFlush) begin
            uop_d       = UopNop;
            uop_d.flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            bias_q      <= 1'b0;
            relu_q      <= 1'b0;
            to_cnt_q    <= '0;
            uop_q       <= UopNop;
            x_q         <= '0;
            w_q         <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ErrNone;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bias_q      <= bias_d;
            relu_q      <= relu_d;
            to_cnt_q    <= to_cnt_d;
            uop_q       <= uop_d;
            x_q         <= x_d;
            w_q         <= w_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cmd_ready_q <= (state_d == StIdle);
            op_ready_q  <= (state_d == StMac);
            busy_q      <= (state_d != StIdle);
            res_valid_q <= (state_d == StResp);
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign op_ready     = op_ready_q;
    assign pe_in_valid  = uop_q.in_valid;
    assign pe_flush     = uop_q.flush;
    assign pe_out_en    = uop_q.out_en;
    assign pe_calc_bias = uop_q.calc_bias;
    assign pe_calc_relu = uop_q.calc_relu;
    assign pe_x         = x_q;
    assign pe_weight    = w_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign err_code     = err_code_q;

endmodule
